// File: rtl/demux_dispatch_pkg.sv
// Shared definitions for the two-port dispatch demux: FSM encoding, default
// word width and a small port-select helper.
package demux_dispatch_pkg;

    localparam int DEF_BW = 6;

    // Each state value equals the number of skid entries it represents.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic logic port_blocked(input logic port, input logic af_0, input logic af_1);
        return port ? af_1 : af_0;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Small circular skid store of {port, data} entries. A push is accepted when
// the store is full only if a pop happens in the same cycle.
module skid_fifo2 #(
    parameter int W     = 7,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/demux_dispatch.sv
// Routes an upstream word stream to one of two downstream FIFOs, absorbing
// backpressure in an in-order skid buffer; all outputs are registered.
module demux_dispatch
    import demux_dispatch_pkg::*;
#(
    parameter int BW         = DEF_BW,
    parameter int SKID_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_in,
    input  logic          port_in,
    input  logic [BW-1:0] data_in,
    input  logic          almost_full_0,
    input  logic          almost_full_1,
    output logic          push_0,
    output logic          push_1,
    output logic [BW-1:0] data_out_0,
    output logic [BW-1:0] data_out_1,
    output logic          pause_out,
    output logic [7:0]    count_0,
    output logic [7:0]    count_1,
    output logic          error_out
);

    state_t        state_q;
    state_t        state_d;
    logic          fwd;
    logic          enq;
    logic          pop;
    logic          drop;
    logic [BW:0]   skid_head;
    logic          skid_empty;
    logic          skid_full;
    logic          head_blocked;
    logic          in_blocked;
    logic          out_vld;
    logic          out_port;
    logic [BW-1:0] out_data;

    skid_fifo2 #(
        .W     (BW + 1),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (enq),
        .pop   (pop),
        .wdata ({port_in, data_in}),
        .head  (skid_head),
        .empty (skid_empty),
        .full  (skid_full)
    );

    assign head_blocked = port_blocked(skid_head[BW], almost_full_0, almost_full_1);
    assign in_blocked   = port_blocked(port_in, almost_full_0, almost_full_1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Once anything is queued, new words go behind the head so global order holds.
    always_comb begin
        state_d = state_q;
        fwd     = 1'b0;
        enq     = 1'b0;
        pop     = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (!in_blocked) begin
                        fwd = 1'b1;
                    end else begin
                        enq     = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN, FULL: begin
                pop  = !skid_empty && !head_blocked;
                enq  = valid_in && (pop || !skid_full);
                drop = valid_in && !enq;
                if (pop && !enq)
                    state_d = (state_q == FULL) ? DRAIN : IDLE;
                else if (enq && !pop)
                    state_d = FULL;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_vld  = fwd || pop;
    assign out_port = pop ? skid_head[BW] : port_in;
    assign out_data = pop ? skid_head[BW-1:0] : data_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            push_0     <= 1'b0;
            push_1     <= 1'b0;
            data_out_0 <= '0;
            data_out_1 <= '0;
            count_0    <= '0;
            count_1    <= '0;
            pause_out  <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            push_0    <= out_vld && !out_port;
            push_1    <= out_vld && out_port;
            pause_out <= (state_d != IDLE);
            if (out_vld && !out_port) begin
                data_out_0 <= out_data;
                count_0    <= count_0 + 8'd1;
            end
            if (out_vld && out_port) begin
                data_out_1 <= out_data;
                count_1    <= count_1 + 8'd1;
            end
            if (drop)
                error_out <= 1'b1;
        end
    end

endmodule

// File: doc/demux_dispatch.md
DEMUX_DISPATCH -- requirements
Module: demux_dispatch

Interface
REQ-001 Parameter BW, default 6, width of the data word.
REQ-002 Parameter SKID_DEPTH, default 2, entries in the internal skid buffer; fixed at 2 for this release.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 valid_in  input  1  upstream word present this cycle; this is the arbiter validMux.
REQ-006 port_in  input  1  destination select, 0 routes to port 0 and 1 routes to port 1; this is the arbiter portMux.
REQ-007 data_in  input  BW  upstream data word.
REQ-008 almost_full_0, almost_full_1  input  1 each  downstream FIFO backpressure, high means no push this cycle.
REQ-009 push_0, push_1  output  1 each  one-cycle write strobe to downstream FIFO 0 or 1.
REQ-010 data_out_0, data_out_1  output  BW each  word qualified by the matching push.
REQ-011 pause_out  output  1  registered request to upstream to stop presenting words.
REQ-012 count_0, count_1  output  8 each  number of words pushed per port.
REQ-013 error_out  output  1  sticky flag, set when a word is dropped.

Function
REQ-014 All outputs shall be registered; a word accepted at edge N with no stall shall appear as push_p/data_out_p at edge N+1, giving one cycle of latency.
REQ-015 The FSM shall have three states: IDLE (skid empty), DRAIN (1 entry), FULL (2 entries).
REQ-016 In IDLE, a valid word whose destination almost_full is low shall be forwarded directly; if that almost_full is high, the word shall be written into the skid buffer and the FSM shall go to DRAIN.
REQ-017 In DRAIN or FULL, the skid head shall be popped and pushed when its destination almost_full is low, at most one pop per cycle.
REQ-018 In DRAIN or FULL, a new valid word shall always enqueue behind the head and never bypass it; global order is preserved, and head-of-line blocking across ports is accepted.
REQ-019 When a pop and an enqueue occur in the same cycle, the occupancy shall be unchanged.
REQ-020 The FSM transitions shall be: DRAIN to IDLE on pop without enqueue; DRAIN to FULL on enqueue without pop; FULL to DRAIN on pop without enqueue.
REQ-021 A valid_in in FULL with no pop in that cycle shall cause the word to be dropped, error_out to set, and the state to remain FULL.
REQ-022 pause_out shall be 1 in the cycle after the occupancy becomes at least 1, and 0 in the cycle after the occupancy becomes 0.
REQ-023 At most one of push_0/push_1 shall be high per cycle.
REQ-024 A data_out shall hold its last pushed value while its push is low.
REQ-025 count_p shall increment by 1 on each push_p and wrap from 255 to 0.
REQ-026 valid_in low shall never change the skid contents.
REQ-027 port_in and data_in shall be ignored while valid_in is low.

Reset
REQ-028 While reset=1, push_0, push_1, pause_out and error_out shall be 0; data_out_0, data_out_1, count_0 and count_1 shall be 0; and the state shall be IDLE with the skid buffer empty.
REQ-029 Reset asserted mid-operation shall discard skid contents without pushing them, and an input word presented in a reset cycle shall not be accepted.
REQ-030 error_out shall clear only by reset.

Structure
REQ-031 A shared package shall hold the state encoding constants IDLE=2'd0, DRAIN=2'd1, FULL=2'd2 and the default BW.
REQ-032 The skid buffer shall be one sub-module, skid_fifo2, providing 2-entry storage of {port, data} with push, pop, empty and full.

Verification
REQ-033 Scenario: reset then valid_in=1, port_in=0, data_in=6'h15 for 1 cycle -> next cycle push_0=1, data_out_0=6'h15, count_0=1, push_1=0.
REQ-034 Scenario: alternating ports 0,1,0,1 with data 1..4 and no backpressure -> pushes on consecutive cycles, count_0=2, count_1=2, pause_out stays 0.
REQ-035 Scenario: almost_full_1=1, send port1 6'h0A, then port0 6'h0B -> both words held, no push, pause_out=1; release almost_full_1 -> push_1 6'h0A then push_0 6'h0B in order, then pause_out=0.
REQ-036 Scenario: almost_full_0=1 with 3 consecutive words to port 0 -> third word dropped, error_out=1 (sticky), and after release exactly two pushes occur.
REQ-037 Scenario: 256 words to port 1 -> count_1 wraps to 0.
REQ-038 Scenario: reset asserted while in FULL -> next cycle state IDLE, no pushes, pause_out=0, error_out=0.
